// File: rtl/mc_correlator_if.sv
// Read-side bus between the correlator and its sample and coefficient RAMs.
// Both RAMs return data one cycle after the read enable.
interface mc_correlator_if #(
    parameter int BITS     = 16,
    parameter int TAPS     = 256,
    parameter int CHANNELS = 4
);
    logic                              x_re;
    logic [$clog2(TAPS)-1:0]           x_raddr;
    logic [BITS-1:0]                   x_rdata;
    logic                              c_re;
    logic [$clog2(CHANNELS*TAPS)-1:0]  c_raddr;
    logic [BITS-1:0]                   c_rdata;

    modport master (
        output x_re, x_raddr, c_re, c_raddr,
        input  x_rdata, c_rdata
    );

    modport slave (
        input  x_re, x_raddr, c_re, c_raddr,
        output x_rdata, c_rdata
    );
endinterface

// File: rtl/mc_correlator.sv
// Multi-channel correlator: for each coefficient set, multiply-accumulate
// TAPS samples read from a circular buffer, then shift, saturate and emit.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one tap address pair per cycle
// DRAIN | last address issued, waiting for read/multiply/accumulate to empty
// OUT   | result strobe cycle; next channel or back to IDLE
module mc_correlator #(
    parameter int BITS     = 16,
    parameter int TAPS     = 256,
    parameter int CHANNELS = 4,
    parameter int ACC      = 40
) (
    input  logic                                    ck,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [$clog2(TAPS)-1:0]                 offset,
    input  logic [4:0]                              shift,
    mc_correlator_if.master                         ram,
    output logic                                    busy,
    output logic                                    out_valid,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic [BITS-1:0]                         out_data,
    output logic                                    overflow,
    output logic                                    done
);
    localparam int XW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                   state;
    logic [XW-1:0]            cnt;
    logic [XW-1:0]            offset_l;
    logic [4:0]               shift_l;
    logic [CW-1:0]            chan;
    logic                     first0;
    logic                     v1, f1, v2, f2;
    logic signed [2*BITS-1:0] xs, cs, prod;
    logic signed [ACC-1:0]    prod_ext, acc, shifted;
    logic [BITS-1:0]          res_data;
    logic                     res_ovf;

    assign xs       = $signed(ram.x_rdata);
    assign cs       = $signed(ram.c_rdata);
    assign prod_ext = prod;
    assign shifted  = acc >>> shift_l;

    // Clamp the shifted accumulator into the output range.
    always_comb begin
        res_data = shifted[BITS-1:0];
        res_ovf  = 1'b0;
        if (shifted > SAT_MAX) begin
            res_data = SAT_MAX[BITS-1:0];
            res_ovf  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res_data = SAT_MIN[BITS-1:0];
            res_ovf  = 1'b1;
        end
    end

    // Sequencer: address generation, drain timer and result registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            offset_l    <= '0;
            shift_l     <= '0;
            chan        <= '0;
            first0      <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            out_chan    <= '0;
            out_data    <= '0;
            overflow    <= 1'b0;
            ram.x_re    <= 1'b0;
            ram.c_re    <= 1'b0;
            ram.x_raddr <= '0;
            ram.c_raddr <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        offset_l    <= offset;
                        shift_l     <= shift;
                        chan        <= '0;
                        busy        <= 1'b1;
                        ram.x_re    <= 1'b1;
                        ram.c_re    <= 1'b1;
                        ram.x_raddr <= offset;
                        ram.c_raddr <= '0;
                        cnt         <= XW'(TAPS-1);
                        first0      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    first0 <= 1'b0;
                    if (cnt == '0) begin
                        ram.x_re <= 1'b0;
                        ram.c_re <= 1'b0;
                        cnt      <= XW'(2);
                        state    <= DRAIN;
                    end else begin
                        cnt         <= cnt - 1'b1;
                        ram.x_raddr <= ram.x_raddr + 1'b1;
                        ram.c_raddr <= ram.c_raddr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        out_chan  <= chan;
                        out_data  <= res_data;
                        overflow  <= res_ovf;
                        done      <= (chan == CW'(CHANNELS-1));
                        state     <= OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (chan == CW'(CHANNELS-1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        chan        <= chan + 1'b1;
                        ram.x_re    <= 1'b1;
                        ram.c_re    <= 1'b1;
                        ram.x_raddr <= offset_l;
                        // c_raddr rests on the previous channel's last tap
                        ram.c_raddr <= ram.c_raddr + 1'b1;
                        cnt         <= XW'(TAPS-1);
                        first0      <= 1'b1;
                        state       <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: RAM data -> registered product -> wrapping accumulator.
    always_ff @(posedge ck) begin
        if (rst) begin
            v1   <= 1'b0;
            f1   <= 1'b0;
            v2   <= 1'b0;
            f2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= ram.x_re;
            f1 <= first0 & ram.x_re;
            v2 <= v1;
            f2 <= f1;
            if (v1)
                prod <= xs * cs;
            if (v2)
                acc <= f2 ? prod_ext : acc + prod_ext;
        end
    end
endmodule

// File: tb/tb_mc_correlator.sv
// Directed bench for mc_correlator (TAPS=8, CHANNELS=2): a behavioural model
// fills a scoreboard at each start, results are checked as they appear.
module tb_mc_correlator;
    localparam int BITS = 16, TAPS = 8, CHANNELS = 2, ACC = 40;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  offset = '0;
    logic [4:0]  shift = '0;
    logic        busy, out_valid, done, overflow;
    logic [0:0]  out_chan;
    logic [15:0] out_data;
    int          cyc = 0;

    mc_correlator_if #(.BITS(BITS), .TAPS(TAPS), .CHANNELS(CHANNELS)) ram ();

    mc_correlator #(.BITS(BITS), .TAPS(TAPS), .CHANNELS(CHANNELS), .ACC(ACC)) dut (
        .ck(ck), .rst(rst), .start(start), .offset(offset), .shift(shift),
        .ram(ram), .busy(busy), .out_valid(out_valid), .out_chan(out_chan),
        .out_data(out_data), .overflow(overflow), .done(done)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    logic signed [15:0] xmem [TAPS];
    logic signed [15:0] cmem [CHANNELS*TAPS];

    always @(posedge ck) begin
        if (ram.x_re) ram.x_rdata <= xmem[ram.x_raddr];
        if (ram.c_re) ram.c_rdata <= cmem[ram.c_raddr];
    end

    int xa_q[$];
    int ca_q[$];
    always @(negedge ck) begin
        if (ram.x_re) begin
            xa_q.push_back(int'(ram.x_raddr));
            ca_q.push_back(int'(ram.c_raddr));
        end
    end

    typedef struct {
        int          chan;
        logic [15:0] data;
        logic        ovf;
        int          due;
        logic        last;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [16:0] model(input int ch, input int off, input int sh);
        logic signed [39:0] a;
        logic signed [39:0] r;
        a = '0;
        for (int k = 0; k < TAPS; k++)
            a = a + 40'(longint'(xmem[(off + k) % TAPS]) * longint'(cmem[ch*TAPS + k]));
        r = a >>> sh;
        if (r > 40'sd32767)       return {1'b1, 16'h7FFF};
        else if (r < -40'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, r[15:0]};
    endfunction

    task automatic do_run(input int off, input int sh, input bit push, output int s);
        exp_t e;
        logic [16:0] m;
        @(negedge ck);
        start  = 1'b1;
        offset = 3'(off);
        shift  = 5'(sh);
        s      = cyc;
        if (push) begin
            for (int c = 0; c < CHANNELS; c++) begin
                m      = model(c, off, sh);
                e.chan = c;
                e.data = m[15:0];
                e.ovf  = m[16];
                e.due  = s + (c + 1) * (TAPS + 4);
                e.last = (c == CHANNELS - 1);
                sb.push_back(e);
            end
        end
        @(negedge ck);
        start  = 1'b0;
        offset = 3'($urandom);
        shift  = 5'($urandom);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic collect();
        exp_t e;
        int   n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            while (!out_valid && n < 60) begin
                @(negedge ck);
                n++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", 1'b0, 1'b1);
            end else begin
                chk("out_cycle", 64'(cyc), 64'(e.due));
                chk("out_chan", out_chan, 64'(e.chan));
                chk("out_data", out_data, e.data);
                chk("overflow", overflow, e.ovf);
                chk("done", done, e.last);
                chk("busy_at_out", busy, 1'b1);
                chk("x_re_at_out", ram.x_re, 1'b0);
                @(negedge ck);
            end
        end
        chk("busy_after_done", busy, 1'b0);
        chk("out_valid_cleared", out_valid, 1'b0);
    endtask

    task automatic fill(input logic [15:0] xv, input logic [15:0] cv);
        for (int i = 0; i < TAPS; i++) xmem[i] = xv;
        for (int i = 0; i < CHANNELS*TAPS; i++) cmem[i] = cv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int strobes;
        fill(16'h0000, 16'h0000);
        ram.x_rdata = '0;
        ram.c_rdata = '0;

        repeat (3) @(negedge ck);
        rst = 1'b0;
        @(negedge ck);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_x_re", ram.x_re, 1'b0);
        chk("rst_c_re", ram.c_re, 1'b0);

        // Full-scale positive, in-range after shift; start pulse mid-run ignored.
        fill(16'h7FFF, 16'h7FFF);
        do_run(0, 18, 1'b1, s);
        repeat (4) @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        collect();

        // One less shift: positive saturation.
        do_run(0, 17, 1'b1, s);
        collect();

        // Negative product, in range.
        fill(16'h7FFF, 16'h8000);
        do_run(0, 18, 1'b1, s);
        collect();

        // Circular offset and per-channel coefficient addressing.
        for (int k = 0; k < TAPS; k++) xmem[k] = 16'(k);
        for (int i = 0; i < CHANNELS*TAPS; i++) cmem[i] = 16'h0000;
        cmem[0]        = 16'h0001;
        cmem[TAPS + 3] = 16'h0001;
        xa_q.delete();
        ca_q.delete();
        do_run(6, 0, 1'b1, s);
        collect();
        chk("addr_count", 64'(xa_q.size()), 64'(CHANNELS*TAPS));
        for (int i = 0; i < CHANNELS*TAPS && i < xa_q.size(); i++) begin
            chk("x_raddr_seq", 64'(xa_q[i]), 64'((6 + i) % TAPS));
            chk("c_raddr_seq", 64'(ca_q[i]), 64'(i));
        end

        // Random data, random offset and shift, including possible saturation.
        for (int i = 0; i < TAPS; i++) xmem[i] = 16'($urandom);
        for (int i = 0; i < CHANNELS*TAPS; i++) cmem[i] = 16'($urandom);
        do_run(3, 14, 1'b1, s);
        collect();
        do_run(5, 9, 1'b1, s);
        collect();

        // Abort: rst mid-run kills the run with no result strobes.
        fill(16'h7FFF, 16'h7FFF);
        do_run(0, 18, 1'b0, s);
        repeat (4) @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        @(negedge ck);
        rst = 1'b1;
        start = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        start = 1'b0;
        chk("abort_cycle", 64'(cyc), 64'(s + 8));
        chk("abort_busy", busy, 1'b0);
        chk("abort_x_re", ram.x_re, 1'b0);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || done) strobes++;
            @(negedge ck);
        end
        chk("abort_no_strobes", 64'(strobes), 64'd0);
        chk("abort_idle_busy", busy, 1'b0);

        // Recovery after abort.
        do_run(0, 18, 1'b1, s);
        collect();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
